ycrcb_stream_arbiter: RTL and testbench

YCRCB_STREAM_ARBITER -- requirements
Module: ycrcb_stream_arbiter

---
 rtl/ycrcb_stream_arbiter_if.sv | 12 +
 rtl/ycrcb_stream_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_ycrcb_stream_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ycrcb_stream_arbiter_if.sv
// Pixel stream bundle: data/valid/last flow from master to slave, ready flows back.
interface ycrcb_stream_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  last;
  logic                  ready;

  modport master (output data, valid, last, input ready);
  modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/ycrcb_stream_arbiter.sv
// Shares one fixed-latency RGB->YCrCb converter between two line-based requesters:
// line-locked round-robin grant, credit-gated issue, tag pipe and show-ahead result FIFO.
module ycrcb_stream_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int CONV_LATENCY = 5,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  ycrcb_stream_arbiter_if.slave  s0,
  ycrcb_stream_arbiter_if.slave  s1,
  output logic [DATA_WIDTH-1:0]  conv_datain,
  output logic                   conv_datain_valid,
  input  logic [DATA_WIDTH-1:0]  conv_dataout,
  input  logic                   conv_dataout_valid,
  ycrcb_stream_arbiter_if.master m,
  output logic                   m_id,
  output logic                   err
);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = $clog2(FIFO_DEPTH + 1);
  localparam int DRAIN_W = $clog2(CONV_LATENCY + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] LOCK0 = 2'd1;
  localparam logic [1:0] LOCK1 = 2'd2;

  typedef struct packed {
    logic id;
    logic last;
    logic valid;
  } tag_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  id;
    logic                  last;
  } entry_t;

  logic [1:0]            state;
  logic                  rr_last;
  logic                  grant_valid;
  logic                  grant_id;
  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [CNT_W:0]        credit;
  logic                  credit_ok;
  logic                  issue;
  logic                  issue_id;
  logic                  issue_last;

  tag_t                  tag_pipe [CONV_LATENCY];
  tag_t                  tag_out;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic                  out_live;
  logic                  push;
  logic                  retire;
  logic                  stray;
  logic [CNT_W-1:0]      inflight;

  entry_t                mem [FIFO_DEPTH];
  entry_t                head;
  logic [PTR_W-1:0]      wptr;
  logic [PTR_W-1:0]      rptr;
  logic [CNT_W-1:0]      fifo_count;
  logic                  full;
  logic                  empty;
  logic                  do_push;
  logic                  pop;

  // ---------------------------------------------------------------- grant
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a latch is inferred.
    grant_valid = 1'b0;
    grant_id    = 1'b0;
    case (state)
      LOCK0: begin
        grant_valid = 1'b1;
        grant_id    = 1'b0;
      end
      LOCK1: begin
        grant_valid = 1'b1;
        grant_id    = 1'b1;
      end
      default: begin
        if (s0.valid && s1.valid) begin
          grant_valid = 1'b1;
          grant_id    = ~rr_last;
        end else if (s0.valid) begin
          grant_valid = 1'b1;
          grant_id    = 1'b0;
        end else if (s1.valid) begin
          grant_valid = 1'b1;
          grant_id    = 1'b1;
        end
      end
    endcase
  end

  // Credit covers every result that may still land in the FIFO, so the converter never stalls.
  assign credit    = (CNT_W+1)'(FIFO_DEPTH) - (CNT_W+1)'(fifo_count) - (CNT_W+1)'(inflight);
  assign credit_ok = ~credit[CNT_W] & (credit != '0);

  assign s0.ready  = grant_valid & ~grant_id & credit_ok;
  assign s1.ready  = grant_valid &  grant_id & credit_ok;

  assign sel_valid = grant_id ? s1.valid : s0.valid;
  assign sel_last  = grant_id ? s1.last  : s0.last;
  assign sel_data  = grant_id ? s1.data  : s0.data;
  assign issue     = grant_valid & sel_valid & credit_ok;

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rr_last <= 1'b1;
    end else if (issue) begin
      if (sel_last) begin
        state   <= IDLE;
        rr_last <= grant_id;
      end else begin
        state   <= grant_id ? LOCK1 : LOCK0;
      end
    end
  end

  // ---------------------------------------------------------------- converter input
  always_ff @(posedge clk) begin
    if (rst) begin
      conv_datain       <= '0;
      conv_datain_valid <= 1'b0;
      issue_id          <= 1'b0;
      issue_last        <= 1'b0;
    end else begin
      conv_datain_valid <= issue;
      if (issue) begin
        conv_datain <= sel_data;
        issue_id    <= grant_id;
        issue_last  <= sel_last;
      end
    end
  end

  // Tag pipe is fed from the registered issue so its tail lines up with conv_dataout_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CONV_LATENCY; i++) tag_pipe[i] <= '0;
    end else begin
      tag_pipe[0] <= '{id: issue_id, last: issue_last, valid: conv_datain_valid};
      for (int i = 1; i < CONV_LATENCY; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_out = tag_pipe[CONV_LATENCY-1];

  // The converter's own valid pipe survives reset; ignore it until it has flushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      drain_cnt <= DRAIN_W'(CONV_LATENCY);
    end else if (drain_cnt != '0) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

  assign out_live = conv_dataout_valid & (drain_cnt == '0);
  assign push     = out_live;
  assign retire   = out_live & tag_out.valid;
  assign stray    = out_live & ~tag_out.valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= '0;
    end else begin
      case ({issue, retire})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
    end
  end

  // ---------------------------------------------------------------- result FIFO
  assign full    = (fifo_count == CNT_W'(FIFO_DEPTH));
  assign empty   = (fifo_count == '0);
  assign pop     = ~empty & m.ready;
  assign do_push = push & ~full;

  // NOTE: storage is not reset; pointers and count are, and outputs are gated by empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= '{data: conv_dataout, id: tag_out.id, last: tag_out.last};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (pop)     rptr <= rptr + 1'b1;
      case ({do_push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  assign head    = mem[rptr];
  assign m.valid = ~empty;
  assign m.data  = empty ? '0 : head.data;
  assign m.last  = ~empty & head.last;
  assign m_id    = ~empty & head.id;

  // ---------------------------------------------------------------- sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      err <= 1'b0;
    end else if (stray || (push && full) || (issue && !credit_ok)) begin
      err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_ycrcb_stream_arbiter.sv
// Randomized bench for ycrcb_stream_arbiter with a behavioural converter and a
// transaction-level reference model (arbitration rules, credit, latency, ordering).
module tb_ycrcb_stream_arbiter;
  localparam int DW    = 32;
  localparam int LAT   = 5;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  ycrcb_stream_arbiter_if #(.DATA_WIDTH(DW)) s0_if ();
  ycrcb_stream_arbiter_if #(.DATA_WIDTH(DW)) s1_if ();
  ycrcb_stream_arbiter_if #(.DATA_WIDTH(DW)) m_if ();

  logic [DW-1:0] conv_datain;
  logic          conv_datain_valid;
  logic [DW-1:0] conv_dataout;
  logic          conv_dataout_valid;
  logic          m_id;
  logic          err;
  logic          inject = 1'b0;

  ycrcb_stream_arbiter #(
    .DATA_WIDTH  (DW),
    .CONV_LATENCY(LAT),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .s0                (s0_if),
    .s1                (s1_if),
    .conv_datain       (conv_datain),
    .conv_datain_valid (conv_datain_valid),
    .conv_dataout      (conv_dataout),
    .conv_dataout_valid(conv_dataout_valid),
    .m                 (m_if),
    .m_id              (m_id),
    .err               (err)
  );

  // Behavioural converter: fixed latency, never reset, arbitrary reversible transform.
  function automatic logic [DW-1:0] conv_fn(input logic [DW-1:0] x);
    return {x[15:0], x[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  logic [DW-1:0] cv_d [LAT];
  logic          cv_v [LAT];
  always @(posedge clk) begin
    cv_v[0] <= conv_datain_valid;
    cv_d[0] <= conv_datain;
    for (int i = 1; i < LAT; i++) begin
      cv_v[i] <= cv_v[i-1];
      cv_d[i] <= cv_d[i-1];
    end
  end
  assign conv_dataout_valid = cv_v[LAT-1] | inject;
  assign conv_dataout       = conv_fn(cv_d[LAT-1]);

  // ---------------------------------------------------------------- bookkeeping
  typedef struct {
    logic [DW-1:0] data;
    logic          id;
    logic          last;
    int            vis;
  } exp_t;

  int n_checks = 0;
  int n_errors = 0;

  exp_t exp_q[$];
  int   grant_log[$];
  int   owner, last_winner, outstanding, n_pop, cyc, first_acc_cyc, first_mv_cyc, n_cvalid;
  int   n_acc [2];
  bit   exp_err;
  bit   chk_m;

  logic          drv_v [2];
  logic [DW-1:0] drv_d [2];
  logic          drv_l [2];
  int            line_left [2];
  bit            drv_en [2];
  int            p_valid, len_min, len_max, m_rdy_pct;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive_inputs();
    for (int r = 0; r < 2; r++) begin
      if (!rst && !drv_v[r] && (drv_en[r] || line_left[r] > 0) &&
          $urandom_range(99) < p_valid) begin
        if (line_left[r] == 0) line_left[r] = $urandom_range(len_max, len_min);
        drv_v[r] = 1'b1;
        drv_d[r] = $urandom;
        drv_l[r] = (line_left[r] == 1);
      end
    end
    s0_if.valid = drv_v[0];
    s0_if.data  = drv_d[0];
    s0_if.last  = drv_l[0];
    s1_if.valid = drv_v[1];
    s1_if.data  = drv_d[1];
    s1_if.last  = drv_l[1];
    m_if.ready  = ($urandom_range(99) < m_rdy_pct);
  endtask

  // Compare the DUT against the rule-level model, then advance the model by the
  // handshakes that the coming edge will commit.
  task automatic sample();
    int   g;
    bit   em;
    exp_t e;
    logic rdy [2];
    rdy[0] = s0_if.ready;
    rdy[1] = s1_if.ready;
    if (owner >= 0)                g = owner;
    else if (drv_v[0] && drv_v[1]) g = 1 - last_winner;
    else if (drv_v[0])             g = 0;
    else if (drv_v[1])             g = 1;
    else                           g = -1;
    check("s0_ready", rdy[0], (g == 0) && (outstanding < DEPTH));
    check("s1_ready", rdy[1], (g == 1) && (outstanding < DEPTH));
    check("err", err, exp_err);

    if (chk_m) begin
      em = (exp_q.size() > 0) && (exp_q[0].vis <= cyc);
      check("m_valid", m_if.valid, em);
      if (m_if.valid && exp_q.size() > 0) begin
        check("m_data", m_if.data, exp_q[0].data);
        check("m_id",   m_id,      exp_q[0].id);
        check("m_last", m_if.last, exp_q[0].last);
      end
    end
    if (m_if.valid && first_mv_cyc < 0) first_mv_cyc = cyc;
    if (m_if.valid && m_if.ready && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      outstanding--;
      n_pop++;
    end

    for (int r = 0; r < 2; r++) begin
      if (drv_v[r] && rdy[r]) begin
        e.data = conv_fn(drv_d[r]);
        e.id   = 1'(r);
        e.last = drv_l[r];
        e.vis  = cyc + 2 + LAT;
        exp_q.push_back(e);
        outstanding++;
        n_acc[r]++;
        grant_log.push_back(r);
        if (first_acc_cyc < 0) first_acc_cyc = cyc;
        if (drv_l[r]) begin
          owner       = -1;
          last_winner = r;
        end else begin
          owner = r;
        end
        line_left[r]--;
        drv_v[r] = 1'b0;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) sample();
    if (conv_dataout_valid) n_cvalid++;
    @(posedge clk);
    cyc++;
    #1;
    drive_inputs();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    inject = 1'b0;
    for (int r = 0; r < 2; r++) begin
      drv_v[r]     = 1'b0;
      drv_l[r]     = 1'b0;
      drv_d[r]     = '0;
      line_left[r] = 0;
      drv_en[r]    = 1'b0;
      n_acc[r]     = 0;
    end
    drive_inputs();
    repeat (n) step();
    rst = 1'b0;
    exp_q.delete();
    grant_log.delete();
    owner         = -1;
    last_winner   = 1;
    outstanding   = 0;
    n_pop         = 0;
    first_acc_cyc = -1;
    first_mv_cyc  = -1;
    n_cvalid      = 0;
    exp_err       = 1'b0;
    chk_m         = 1'b1;
  endtask

  task automatic drain();
    bit busy;
    drv_en[0] = 1'b0;
    drv_en[1] = 1'b0;
    p_valid   = 100;
    m_rdy_pct = 100;
    busy = 1'b1;
    for (int i = 0; i < 400 && busy; i++) begin
      step();
      busy = (exp_q.size() > 0) || drv_v[0] || drv_v[1] || (line_left[0] > 0) || (line_left[1] > 0);
    end
    check("drain_timeout", busy, 1'b0);
  endtask

  task automatic check_reset_outputs();
    check("rst_conv_valid", conv_datain_valid, 1'b0);
    check("rst_conv_data",  conv_datain,       '0);
    check("rst_m_valid",    m_if.valid,        1'b0);
    check("rst_m_data",     m_if.data,         '0);
    check("rst_m_last",     m_if.last,         1'b0);
    check("rst_m_id",       m_id,              1'b0);
    check("rst_err",        err,               1'b0);
    check("rst_s0_ready",   s0_if.ready,       1'b0);
    check("rst_s1_ready",   s1_if.ready,       1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_g [6];
    cyc       = 0;
    p_valid   = 100;
    len_min   = 1;
    len_max   = 1;
    m_rdy_pct = 100;

    // Reset state.
    do_reset(3);
    check_reset_outputs();

    // Single 3-beat line from s0: latency and tagging.
    line_left[0] = 3;
    drain();
    check("lat_first", first_mv_cyc - first_acc_cyc, 2 + LAT);
    check("beats_line", n_pop, 3);

    // Both requesters with 2-beat lines: line-locked round robin.
    do_reset(2);
    len_min = 2;
    len_max = 2;
    drv_en[0] = 1'b1;
    drv_en[1] = 1'b1;
    for (int i = 0; i < 40 && grant_log.size() < 6; i++) step();
    exp_g = '{0, 0, 1, 1, 0, 0};
    for (int i = 0; i < 6; i++)
      check($sformatf("grant_order[%0d]", i), (grant_log.size() > i) ? grant_log[i] : 99, exp_g[i]);
    drain();

    // Downstream stalled: credit limits acceptance to the FIFO depth.
    do_reset(2);
    m_rdy_pct = 0;
    len_min   = 4;
    len_max   = 4;
    drv_en[0] = 1'b1;
    repeat (30) step();
    check("acc_stalled", n_acc[0], DEPTH);
    check("s0_ready_stalled", s0_if.ready, 1'b0);
    check("err_stalled", err, 1'b0);
    drain();
    check("no_loss_stalled", n_pop, n_acc[0]);

    // Randomized traffic with varying downstream pressure.
    do_reset(2);
    drv_en[0] = 1'b1;
    drv_en[1] = 1'b1;
    p_valid   = 60;
    len_min   = 1;
    len_max   = 4;
    for (int i = 0; i < 2000; i++) begin
      if (i % 150 == 0)
        m_rdy_pct = ($urandom_range(2) == 0) ? 0 : ($urandom_range(1) == 1 ? 40 : 100);
      step();
    end
    drain();
    check("rand_no_loss", n_pop, n_acc[0] + n_acc[1]);
    check("rand_s1_served", n_acc[1] > 0, 1'b1);

    // Reset mid-line with three beats in the converter.
    do_reset(2);
    line_left[0] = 5;
    for (int i = 0; i < 20 && n_acc[0] < 3; i++) step();
    check("acc_before_rst", n_acc[0], 3);
    do_reset(1);
    repeat (8) step();
    check("stale_valids", n_cvalid, 3);
    len_min   = 2;
    len_max   = 2;
    drv_en[0] = 1'b1;
    drv_en[1] = 1'b1;
    for (int i = 0; i < 10 && grant_log.size() == 0; i++) step();
    check("grant_after_rst", (grant_log.size() > 0) ? grant_log[0] : 99, 0);
    drain();

    // Stray converter valid on the last drain cycle: ignored.
    do_reset(2);
    repeat (LAT - 1) step();
    inject = 1'b1;
    step();
    inject = 1'b0;
    repeat (3) step();
    check("err_in_drain", err, 1'b0);

    // Stray converter valid right after the drain window: sticky error.
    do_reset(2);
    repeat (LAT) step();
    inject = 1'b1;
    chk_m  = 1'b0;
    step();
    inject  = 1'b0;
    exp_err = 1'b1;
    repeat (4) step();
    check("err_sticky", err, 1'b1);
    do_reset(2);
    check("err_cleared", err, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
